// File: rtl/cipher_seq_ctrl.sv
// cipher_seq_ctrl: feeds latched plaintext/key shares byte-serially to a masked cipher core and gathers the ciphertext shares
module cipher_seq_ctrl #(
    parameter int TIMEOUT = 2048
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] pt_s0,
    input  logic [127:0] pt_s1,
    input  logic [127:0] key_s0,
    input  logic [127:0] key_s1,
    input  logic         start,
    output logic         ready,
    output logic [127:0] ct_s0,
    output logic [127:0] ct_s1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err,
    input  logic         fresh_in,
    output logic         core_rst,
    output logic         core_fresh,
    output logic [7:0]   core_in1,
    output logic [7:0]   core_in2,
    output logic [7:0]   core_key1,
    output logic [7:0]   core_key2,
    input  logic [7:0]   core_out1,
    input  logic [7:0]   core_out2,
    input  logic         core_done
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, OUT} state_t;
    state_t state, state_nx;
    logic [3:0] idx;
    logic [CW-1:0] cnt;
    logic [127:0] pt0, pt1, key0, key1;
    logic [6:0] sel;
    logic load, tmo, cap;
    assign sel = {~idx, 3'b000};
    assign load = state == LOAD;
    assign tmo = state == RUN && !core_done && cnt == CW'(TIMEOUT - 1);
    assign cap = (state == RUN && core_done) || state == DRAIN;
    assign ready = state == IDLE;
    assign out_valid = state == OUT;
    assign core_rst = ready || (load && idx == 4'd0) || tmo;
    assign core_fresh = fresh_in;
    assign core_in1 = load ? pt0[sel +: 8] : 8'h00;
    assign core_in2 = load ? pt1[sel +: 8] : 8'h00;
    assign core_key1 = load ? key0[sel +: 8] : 8'h00;
    assign core_key2 = load ? key1[sel +: 8] : 8'h00;
    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    // next-state selection
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = idx == 4'd15 ? RUN : LOAD;
            RUN:     state_nx = core_done ? DRAIN : (tmo ? IDLE : RUN);
            DRAIN:   state_nx = idx == 4'd15 ? OUT : DRAIN;
            OUT:     state_nx = out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end
    // byte index, timeout counter, share latches and ciphertext capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx <= 4'd0;
            cnt <= '0;
            err <= 1'b0;
            pt0 <= '0;
            pt1 <= '0;
            key0 <= '0;
            key1 <= '0;
            ct_s0 <= '0;
            ct_s1 <= '0;
        end else begin
            idx <= (load || cap) ? idx + 4'd1 : 4'd0;
            cnt <= state == RUN ? cnt + CW'(1) : '0;
            err <= tmo;
            if (ready && start) begin
                pt0 <= pt_s0;
                pt1 <= pt_s1;
                key0 <= key_s0;
                key1 <= key_s1;
            end
            if (cap) begin
                ct_s0[sel +: 8] <= core_out1;
                ct_s1[sel +: 8] <= core_out2;
            end
        end
    end
endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// tb_cipher_seq_ctrl: randomized and directed checks of the cipher sequencer against a cycle-count model and a byte-serial core stand-in
module tb_cipher_seq_ctrl;
    localparam int TMO = 64;
    localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0, rst = 1'b0;
    logic [127:0] pt_s0 = '0, pt_s1 = '0, key_s0 = '0, key_s1 = '0;
    logic start = 1'b0, out_ready = 1'b0, fresh_in = 1'b0, core_done = 1'b0;
    logic ready, out_valid, err, core_rst, core_fresh;
    logic [127:0] ct_s0, ct_s1;
    logic [7:0] core_in1, core_in2, core_key1, core_key2;
    logic [7:0] core_out1 = 8'h00, core_out2 = 8'h00;
    int n_chk = 0, n_fail = 0;
    int core_lat = 0;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    cipher_seq_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .pt_s0(pt_s0), .pt_s1(pt_s1), .key_s0(key_s0), .key_s1(key_s1),
        .start(start), .ready(ready),
        .ct_s0(ct_s0), .ct_s1(ct_s1), .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .fresh_in(fresh_in),
        .core_rst(core_rst), .core_fresh(core_fresh),
        .core_in1(core_in1), .core_in2(core_in2), .core_key1(core_key1), .core_key2(core_key2),
        .core_out1(core_out1), .core_out2(core_out2), .core_done(core_done)
    );

    function automatic logic [7:0] byte_of(logic [127:0] v, int i);
        return 8'(v >> (8 * (15 - i)));
    endfunction

    function automatic logic [127:0] set_byte(logic [127:0] v, int i, logic [7:0] b);
        int s = 8 * (15 - i);
        return (v & ~(128'hff << s)) | (128'(b) << s);
    endfunction

    // Stand-in cipher: the real FIPS-197 answer for the reference vector, a keyed byte rotation otherwise
    function automatic logic [127:0] cipher(logic [127:0] p, logic [127:0] k);
        if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return {p[87:0], p[127:88]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Byte-serial masked core stand-in: gathers 16 bytes after core_rst, waits core_lat cycles, streams 16 masked result bytes
    initial begin : core_model
        logic [127:0] cp, ck, cc;
        int k, w, j;
        bit waiting, emitting;
        logic [7:0] mask;
        cp = '0; ck = '0; cc = '0; k = 16; w = 0; j = 0; waiting = 0; emitting = 0;
        forever begin
            @(posedge clk);
            #1;
            if (core_rst === 1'b1) begin
                cp = set_byte('0, 0, core_in1 ^ core_in2);
                ck = set_byte('0, 0, core_key1 ^ core_key2);
                k = 1; waiting = 0; emitting = 0;
            end else if (k < 16) begin
                cp = set_byte(cp, k, core_in1 ^ core_in2);
                ck = set_byte(ck, k, core_key1 ^ core_key2);
                k++;
                if (k == 16) begin
                    cc = cipher(cp, ck);
                    w = core_lat;
                    waiting = core_lat >= 0;
                end
            end else if (waiting) begin
                if (w == 0) begin
                    waiting = 0; emitting = 1; j = 0;
                end else w--;
            end
            if (emitting && j < 16) begin
                mask = 8'($urandom);
                core_done = 1'b1;
                core_out1 = mask;
                core_out2 = byte_of(cc, j) ^ mask;
                j++;
            end else begin
                emitting = 0;
                core_done = 1'b0;
                core_out1 = 8'($urandom);
                core_out2 = 8'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        fresh_in = 1'($urandom);
    end

    // Reference model: job progress kept as counts (cycles since acceptance, bytes captured, cycles waited)
    int m_job = -1, m_cap = 0, m_wait = 0;
    logic m_err = 1'b0;
    logic [127:0] m_pt0 = '0, m_pt1 = '0, m_k0 = '0, m_k1 = '0, m_ct0 = '0, m_ct1 = '0;

    always @(posedge clk) if (!rst) armed <= 1'b1;

    always @(negedge clk) begin
        bit idle, ld, run, outp;
        idle = m_job < 0;
        ld = !idle && m_job < 16;
        run = !idle && !ld && m_cap == 0;
        outp = !idle && m_cap == 16;
        if (armed) begin
            chk("ready", ready, idle);
            chk("out_valid", out_valid, outp);
            chk("err", err, m_err);
            chk("core_rst", core_rst, idle || (ld && m_job == 0) || (run && m_wait == TMO - 1 && !core_done));
            chk("core_fresh", core_fresh, fresh_in);
            chk("core_in1", core_in1, ld ? byte_of(m_pt0, m_job) : 8'h00);
            chk("core_in2", core_in2, ld ? byte_of(m_pt1, m_job) : 8'h00);
            chk("core_key1", core_key1, ld ? byte_of(m_k0, m_job) : 8'h00);
            chk("core_key2", core_key2, ld ? byte_of(m_k1, m_job) : 8'h00);
            chk("ct_s0", ct_s0, m_ct0);
            chk("ct_s1", ct_s1, m_ct1);
        end
        m_err = 1'b0;
        if (!rst) begin
            m_job = -1; m_cap = 0; m_wait = 0;
            m_pt0 = '0; m_pt1 = '0; m_k0 = '0; m_k1 = '0; m_ct0 = '0; m_ct1 = '0;
        end else if (idle) begin
            if (start) begin
                m_pt0 = pt_s0; m_pt1 = pt_s1; m_k0 = key_s0; m_k1 = key_s1;
                m_job = 0; m_cap = 0; m_wait = 0;
            end
        end else if (ld) m_job++;
        else if (run) begin
            if (core_done) begin
                m_ct0 = set_byte(m_ct0, 0, core_out1);
                m_ct1 = set_byte(m_ct1, 0, core_out2);
                m_cap = 1;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_err = 1'b1;
                    m_job = -1;
                end
            end
        end else if (!outp) begin
            m_ct0 = set_byte(m_ct0, m_cap, core_out1);
            m_ct1 = set_byte(m_ct1, m_cap, core_out2);
            m_cap++;
        end else if (out_ready) m_job = -1;
    end

    task automatic submit(logic [127:0] p, logic [127:0] k, int lat);
        logic [127:0] r0 = rnd128(), r1 = rnd128();
        int n = 0;
        core_lat = lat;
        pt_s0 = r0; pt_s1 = p ^ r0; key_s0 = r1; key_s1 = k ^ r1;
        while (!ready && n < 200) begin
            cyc();
            n++;
        end
        chk("ready_for_start", ready, 1'b1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        pt_s0 = rnd128(); pt_s1 = rnd128(); key_s0 = rnd128(); key_s1 = rnd128();
    endtask

    task automatic finish(int hold, logic [127:0] exp);
        int n = 0;
        while (!out_valid && n < 400) begin
            start = 1'($urandom);
            out_ready = 1'($urandom);
            cyc();
            n++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("result_arrives", out_valid, 1'b1);
        chk("result", ct_s0 ^ ct_s1, exp);
        repeat (hold) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("idle_after_handshake", ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p, k;
        int n;
        repeat (3) cyc();
        chk("rst_ready", ready, 1'b1);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ct_s0", ct_s0, 128'h0);
        chk("rst_ct_s1", ct_s1, 128'h0);
        chk("rst_core_in1", core_in1, 8'h00);
        rst = 1'b1;
        cyc();

        submit(FIPS_PT, FIPS_KEY, 5);
        chk("load0_pt", core_in1 ^ core_in2, 8'h32);
        chk("load0_key", core_key1 ^ core_key2, 8'h2b);
        chk("load0_rst", core_rst, 1'b1);
        repeat (15) cyc();
        chk("load15_pt", core_in1 ^ core_in2, 8'h34);
        chk("load15_key", core_key1 ^ core_key2, 8'h3c);
        chk("load15_rst", core_rst, 1'b0);
        finish(0, FIPS_CT);

        p = rnd128(); k = rnd128();
        submit(p, k, 3);
        n = 0;
        while (!out_valid && n < 200) begin
            cyc();
            n++;
        end
        chk("bp_reach", out_valid, 1'b1);
        for (int i = 0; i < 50; i++) begin
            start = i == 10;
            cyc();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_ready", ready, 1'b0);
            chk("bp_ct", ct_s0 ^ ct_s1, cipher(p, k));
        end
        start = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("bp_release_ready", ready, 1'b1);
        cyc();
        chk("bp_no_queue", ready, 1'b1);
        chk("bp_core_rst", core_rst, 1'b1);

        submit(rnd128(), rnd128(), -1);
        repeat (16) cyc();
        chk("tmo_run_ready", ready, 1'b0);
        chk("tmo_run_rst", core_rst, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            cyc();
            chk("tmo_err", err, i == 64);
        end
        chk("tmo_core_rst", core_rst, 1'b1);
        chk("tmo_ready", ready, 1'b1);
        cyc();
        chk("tmo_err_pulse", err, 1'b0);

        submit(rnd128(), rnd128(), 4);
        n = 0;
        while (!core_done && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_reach", core_done, 1'b1);
        repeat (7) cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ct_s0", ct_s0, 128'h0);
        chk("mid_rst_ct_s1", ct_s1, 128'h0);
        submit(FIPS_PT, FIPS_KEY, 10);
        finish(2, FIPS_CT);

        submit(FIPS_PT, FIPS_KEY, 0);
        finish(0, FIPS_CT);
        p = rnd128(); k = rnd128();
        chk("b2b_ready", ready, 1'b1);
        submit(p, k, 7);
        finish(1, cipher(p, k));

        for (int j = 0; j < 20; j++) begin
            p = rnd128(); k = rnd128();
            submit(p, k, int'($urandom_range(0, 40)));
            finish(int'($urandom_range(0, 6)), cipher(p, k));
        end
        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cipher_seq_ctrl.md
CIPHER_SEQ_CTRL -- requirements
Module: cipher_seq_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter TIMEOUT, default 2048, giving the maximum cycles in RUN waiting for core_done.
Ports:
REQ-002 The block SHALL have port clk  input  1  single system clock; all logic SHALL be on the rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have ports pt_s0, pt_s1  input  128 each  plaintext shares; byte 0 is bits [127:120].
REQ-005 The block SHALL have ports key_s0, key_s1  input  128 each  key shares, with the same byte order.
REQ-006 The block SHALL have ports start (input, 1) and ready (output, 1)  job handshake.
REQ-007 The block SHALL have ports ct_s0, ct_s1  output  128 each  ciphertext shares.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1)  result handshake.
REQ-009 The block SHALL have port err  output  1  one-cycle pulse on timeout.
REQ-010 The block SHALL have port fresh_in  input  1  fresh random bit from the RNG.
REQ-011 The block SHALL have port core_rst  output  1  active-high reset to the byte-serial masked cipher core.
REQ-012 The block SHALL have port core_fresh  output  1  fresh random bit to the core.
REQ-013 The block SHALL have ports core_in1, core_in2, core_key1, core_key2  output  8 each  share bytes to the core.
REQ-014 The block SHALL have ports core_out1, core_out2  input  8 each  output share bytes from the core.
REQ-015 The block SHALL have port core_done  input  1  high while the core presents ciphertext bytes.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, RUN, DRAIN and OUT.
REQ-017 IDLE: ready=1, core_rst=1; start=1 SHALL latch all four share inputs into internal registers and enter LOAD with idx=0.
REQ-018 LOAD: the block SHALL drive share byte idx of each latched register on core_in1/2 and core_key1/2 for 16 cycles, idx 0..15.
REQ-019 LOAD: core_rst SHALL be 1 only in the idx=0 cycle; after idx=15 the block SHALL enter RUN with the timeout counter at 0.
REQ-020 RUN: each cycle with core_done=0 SHALL increment the counter; at counter=TIMEOUT-1 the block SHALL pulse err, assert core_rst and return to IDLE.
REQ-021 RUN with core_done=1 SHALL capture core_out1/2 as byte 0 of ct_s0/ct_s1 and enter DRAIN with idx=1.
REQ-022 DRAIN SHALL capture byte idx on each of the next 15 cycles regardless of core_done, then enter OUT.
REQ-023 OUT: out_valid=1 and ct_s0/ct_s1 stable; on out_valid&&out_ready the block SHALL enter IDLE; out_ready at any other time SHALL be ignored.
REQ-024 ready SHALL be 0 in every state except IDLE; start outside IDLE SHALL be ignored and not queued.
REQ-025 core_fresh SHALL equal fresh_in combinationally in every state.
REQ-026 The block SHALL never XOR the two shares of any value together, and the shares SHALL never share a combinational path to any output.
REQ-027 Core byte outputs SHALL be 0 in IDLE and OUT, and the latched share registers SHALL retain their values until the next start.
REQ-028 Latency: the block SHALL take 16 LOAD cycles plus the core time to core_done plus 16 capture cycles, and out_valid SHALL rise on the cycle after byte 15 is captured.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL enter IDLE, clear idx, the counter, ct_s0, ct_s1, the latched registers and all core byte outputs to 0, and set out_valid=0, err=0, ready=1 and core_rst=1 on the following cycle.
REQ-030 Reset SHALL override every state and the result SHALL be discarded, including a reset asserted mid-LOAD, RUN, DRAIN or OUT.

Verification
REQ-031 FIPS-197 vector: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, random shares; the bench SHALL require ct_s0^ct_s1=3925841d02dc09fbdc118597196a0b32.
REQ-032 LOAD order: the bench SHALL check that cycle 0 drives core_in1^core_in2=32 and core_key1^core_key2=2b with core_rst=1, and that cycle 15 drives 34/3c with core_rst=0.
REQ-033 Back-pressure: with out_ready held 0 for 50 cycles, the bench SHALL require out_valid=1, stable ct values, ready=0 and start ignored, and on release IDLE with ready=1 after one handshake.
REQ-034 Timeout: with TIMEOUT=64 and core_done tied 0, the bench SHALL require an err pulse exactly 64 cycles after RUN entry, then core_rst=1 and ready=1.
REQ-035 Reset mid-DRAIN at idx=7: the bench SHALL require IDLE, ct_s0=ct_s1=0 and out_valid=0, and a new job SHALL complete correctly.
REQ-036 Back-to-back: for two jobs with start re-asserted in the first IDLE cycle after OUT, the bench SHALL require both ciphertexts to be correct.
